// File: rtl/cpu_state_tx.sv
`default_nettype none
// ============================================================================
// Module      : cpu_state_tx
// Description : Snapshots the CPU PC and R0..R7 whenever the PC changes (or
//               on a halt rising edge) and streams each snapshot as a framed
//               byte sequence over a valid/ready byte interface:
//                 sync (A5 / 5A for halt), PC, R0..R7 (big-endian), XOR csum.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_state_tx #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,       // asynchronous, active-low
  input  logic                  en,
  input  logic                  halt,
  input  logic [DATA_W-1:0]     pc,
  input  logic [8*DATA_W-1:0]   regs,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [7:0]            overrun
);

  localparam int c_NB     = DATA_W / 8;
  localparam int c_NPAY   = 9 * c_NB;
  localparam int c_SNAP_W = 9 * DATA_W;
  localparam int c_IDX_W  = $clog2(c_NPAY);

  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NPAY - 1);

  localparam logic [7:0] c_SYNC_RUN  = 8'hA5;
  localparam logic [7:0] c_SYNC_HALT = 8'h5A;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_SYNC    = 2'd1;
  localparam logic [1:0] c_PAYLOAD = 2'd2;
  localparam logic [1:0] c_CSUM    = 2'd3;

  logic [1:0]          r_state;
  logic                r_first;
  logic [DATA_W-1:0]   r_last_pc;
  logic                r_halt_q;
  logic                r_pending;
  logic                r_pending_halt;
  logic [7:0]          r_overrun;
  logic [c_SNAP_W-1:0] r_snap;
  logic [c_IDX_W-1:0]  r_idx;
  logic [7:0]          r_csum;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;

  logic                w_halt_rise;
  logic                w_trig;
  logic                w_busy;
  logic                w_capture;
  logic                w_hs;
  logic                w_frame_halt;
  logic [c_SNAP_W-1:0] w_snap_in;

  // Snapshot word order in transmission order: PC in the MSBs, then R0..R7,
  // so the frame can be emitted by shifting out the top byte.
  assign w_snap_in[8*DATA_W +: DATA_W] = pc;

  for (genvar gi = 0; gi < 8; gi++) begin : g_regs
    assign w_snap_in[(7-gi)*DATA_W +: DATA_W] = regs[gi*DATA_W +: DATA_W];
  end

  assign w_halt_rise  = halt & ~r_halt_q;
  assign w_trig       = en & (r_first | (pc != r_last_pc) | w_halt_rise);
  assign w_busy       = (r_state != c_IDLE);
  assign w_capture    = ~w_busy & (w_trig | r_pending);
  assign w_hs         = r_tx_valid & tx_ready;
  // A frame is a halt frame if a halt rise was deferred or arrives right now.
  assign w_frame_halt = r_pending_halt | (w_trig & w_halt_rise);

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = w_busy;
  assign overrun  = r_overrun;

  // Trigger history: first-frame flag, last seen PC and halt level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first   <= 1'b1;
      r_last_pc <= '0;
      r_halt_q  <= 1'b0;
    end else if (w_trig) begin
      r_first   <= 1'b0;
      r_last_pc <= pc;
      r_halt_q  <= halt;
    end
  end

  // Triggers arriving while busy: coalesce one into pending, count the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending      <= 1'b0;
      r_pending_halt <= 1'b0;
      r_overrun      <= 8'd0;
    end else if (w_busy) begin
      if (w_trig) begin
        if (!r_pending) begin
          r_pending <= 1'b1;
        end else if (r_overrun != 8'hFF) begin
          r_overrun <= r_overrun + 8'd1;
        end
        if (w_halt_rise) begin
          r_pending_halt <= 1'b1;
        end
      end
    end else if (w_capture) begin
      r_pending      <= 1'b0;
      r_pending_halt <= 1'b0;
    end
  end

  // Frame sequencer: capture snapshot, emit sync, payload bytes and checksum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_IDLE;
      r_snap     <= '0;
      r_idx      <= '0;
      r_csum     <= 8'd0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_capture) begin
            r_snap     <= w_snap_in;
            r_idx      <= '0;
            r_csum     <= 8'd0;
            r_tx_data  <= w_frame_halt ? c_SYNC_HALT : c_SYNC_RUN;
            r_tx_valid <= 1'b1;
            r_state    <= c_SYNC;
          end
        end
        c_SYNC: begin
          if (w_hs) begin
            r_tx_data <= r_snap[c_SNAP_W-1 -: 8];
            r_snap    <= r_snap << 8;
            r_state   <= c_PAYLOAD;
          end
        end
        c_PAYLOAD: begin
          if (w_hs) begin
            r_csum <= r_csum ^ r_tx_data;
            if (r_idx == c_LAST_IDX) begin
              // Checksum includes the byte being accepted on this edge.
              r_tx_data <= r_csum ^ r_tx_data;
              r_state   <= c_CSUM;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_tx_data <= r_snap[c_SNAP_W-1 -: 8];
              r_snap    <= r_snap << 8;
            end
          end
        end
        c_CSUM: begin
          if (w_hs) begin
            r_tx_valid <= 1'b0;
            r_state    <= c_IDLE;
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_state_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_state_tx
// Description : Self-checking bench for cpu_state_tx. A frame-level reference
//               model (queue of expected bytes) is stepped once per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_state_tx;

  logic         clk;
  logic         rst;
  logic         en;
  logic         halt;
  logic [31:0]  pc;
  logic [255:0] regs;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic [7:0]   overrun;

  int n_checks;
  int n_pass;

  // Reference model state
  logic [7:0]  q[$];
  bit          m_first;
  logic [31:0] m_last_pc;
  bit          m_halt_q;
  bit          m_pending;
  bit          m_pend_halt;
  int          m_ovr;

  typedef struct {
    logic        en;
    logic        halt;
    logic [31:0] pc;
    logic        ready;
    int          cycles;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [7:0]  exp_ovr;
  } vec_t;

  vec_t tbl[13];

  cpu_state_tx #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .halt     (halt),
    .pc       (pc),
    .regs     (regs),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_first     = 1'b1;
    m_last_pc   = '0;
    m_halt_q    = 1'b0;
    m_pending   = 1'b0;
    m_pend_halt = 1'b0;
    m_ovr       = 0;
  endtask

  // Expected frame bytes computed straight from the frame layout.
  task automatic build_frame(input logic [31:0] p, input logic [255:0] r, input bit h);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [7:0]  b;
    cs = 8'h00;
    q.push_back(h ? 8'h5A : 8'hA5);
    for (int wi = 0; wi < 9; wi++) begin
      w = (wi == 0) ? p : r[(wi-1)*32 +: 32];
      for (int bi = 3; bi >= 0; bi--) begin
        b = w[bi*8 +: 8];
        q.push_back(b);
        cs = cs ^ b;
      end
    end
    q.push_back(cs);
  endtask

  // Compare outputs against the model, then advance model and DUT one edge.
  task automatic cycle();
    bit m_valid;
    bit hrise;
    bit trig;
    m_valid = (q.size() != 0);
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_valid});
    chk("busy", {31'd0, busy}, {31'd0, m_valid});
    chk("overrun", {24'd0, overrun}, m_ovr);
    if (m_valid) chk("tx_data", {24'd0, tx_data}, {24'd0, q[0]});
    hrise = halt && !m_halt_q;
    trig  = en && (m_first || (pc != m_last_pc) || hrise);
    if (m_valid) begin
      if (tx_ready) void'(q.pop_front());
      if (trig) begin
        if (!m_pending) m_pending = 1'b1;
        else if (m_ovr < 255) m_ovr++;
        if (hrise) m_pend_halt = 1'b1;
      end
    end else if (trig || m_pending) begin
      build_frame(pc, regs, m_pend_halt || (trig && hrise));
      m_pending   = 1'b0;
      m_pend_halt = 1'b0;
    end
    if (trig) begin
      m_first   = 1'b0;
      m_last_pc = pc;
      m_halt_q  = halt;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] first_frame_byte(input int k);
    int w;
    if (k == 0) return 8'hA5;
    if (k == 37) return 8'h00;
    w = (k - 1) / 4;
    if (w == 0) return 8'h00;
    return 8'(8'h11 * (w - 1));
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    tbl[0]  = '{1'b1, 1'b0, 32'd4,  1'b1, 1,  1'b1, 8'hA5, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 32'd8,  1'b1, 1,  1'b1, 8'h00, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 32'd12, 1'b1, 1,  1'b1, 8'h00, 8'd1};
    tbl[3]  = '{1'b1, 1'b0, 32'd16, 1'b1, 1,  1'b1, 8'h00, 8'd2};
    tbl[4]  = '{1'b1, 1'b0, 32'd16, 1'b1, 1,  1'b1, 8'h04, 8'd2};
    tbl[5]  = '{1'b1, 1'b0, 32'd16, 1'b1, 34, 1'b0, 8'h00, 8'd2};
    tbl[6]  = '{1'b1, 1'b0, 32'd16, 1'b1, 1,  1'b1, 8'hA5, 8'd2};
    tbl[7]  = '{1'b1, 1'b0, 32'd16, 1'b1, 4,  1'b1, 8'h10, 8'd2};
    tbl[8]  = '{1'b1, 1'b0, 32'd16, 1'b1, 34, 1'b0, 8'h00, 8'd2};
    tbl[9]  = '{1'b1, 1'b1, 32'd16, 1'b1, 1,  1'b1, 8'h5A, 8'd2};
    tbl[10] = '{1'b1, 1'b1, 32'd16, 1'b1, 38, 1'b0, 8'h00, 8'd2};
    tbl[11] = '{1'b1, 1'b1, 32'd16, 1'b1, 50, 1'b0, 8'h00, 8'd2};
    tbl[12] = '{1'b1, 1'b0, 32'd16, 1'b1, 5,  1'b0, 8'h00, 8'd2};

    en       = 1'b1;
    halt     = 1'b0;
    pc       = 32'd0;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) regs[i*32 +: 32] = 32'h11111111 * i;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_overrun", {24'd0, overrun}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // First frame: explicit byte sequence, 38 consecutive valid cycles.
    for (int k = 0; k < 38; k++) begin
      chk("first_valid", {31'd0, tx_valid}, 32'd1);
      chk("first_byte", {24'd0, tx_data}, {24'd0, first_frame_byte(k)});
      cycle();
    end
    chk("first_done_busy", {31'd0, busy}, 32'd0);
    chk("first_done_valid", {31'd0, tx_valid}, 32'd0);

    // Coalescing, snapshot freeze and halt frames.
    for (int t = 0; t < 13; t++) begin
      en       = tbl[t].en;
      halt     = tbl[t].halt;
      pc       = tbl[t].pc;
      tx_ready = tbl[t].ready;
      repeat (tbl[t].cycles) cycle();
      chk("tbl_valid", {31'd0, tx_valid}, {31'd0, tbl[t].exp_valid});
      if (tbl[t].exp_valid) chk("tbl_data", {24'd0, tx_data}, {24'd0, tbl[t].exp_data});
      chk("tbl_overrun", {24'd0, overrun}, {24'd0, tbl[t].exp_ovr});
    end

    // Randomized traffic with backpressure, mid-frame input changes, en drops.
    for (int c = 0; c < 3000; c++) begin
      tx_ready = ($urandom_range(0, 2) != 0);
      en       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 29) == 0) pc = pc + 32'($urandom_range(1, 3)) * 4;
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)*32 +: 32] = $urandom;
      if ($urandom_range(0, 49) == 0) halt = ~halt;
      cycle();
    end
    tx_ready = 1'b1;
    en       = 1'b1;
    halt     = 1'b0;
    repeat (100) cycle();
    chk("drain_busy", {31'd0, busy}, 32'd0);

    // Reset asserted at byte 10 of a frame.
    pc = pc + 32'd4;
    cycle();
    repeat (10) cycle();
    rst = 1'b0;
    #1;
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_overrun", {24'd0, overrun}, 32'd0);
    chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle();
    chk("midrst_fresh_sync", {24'd0, tx_data}, 32'hA5);
    chk("midrst_fresh_valid", {31'd0, tx_valid}, 32'd1);

    // Overrun saturation: 300 PC changes with the sink stalled.
    tx_ready = 1'b0;
    for (int c = 0; c < 300; c++) begin
      pc = pc + 32'd4;
      cycle();
    end
    chk("ovr_saturated", {24'd0, overrun}, 32'd255);
    chk("ovr_stall_byte", {24'd0, tx_data}, 32'hA5);
    tx_ready = 1'b1;
    repeat (100) cycle();
    chk("final_busy", {31'd0, busy}, 32'd0);
    chk("final_overrun", {24'd0, overrun}, 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_state_tx.md
# cpu_state_tx

Hardware counterpart to the bench-side register monitor. Snapshots the CPU's PC and R0–R7 whenever the PC changes, and serializes each snapshot as a framed byte stream. Output is a valid/ready byte interface, so a UART or debug FIFO can carry the trace off-chip. Sits beside `CPU`; the probe taps the PC register and register-bank outputs.

## Interface
- `DATA_W`, 32: width of PC and each register. Must be a multiple of 8. `B = DATA_W/8` bytes per word.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: trace enable. When 0, no new triggers are taken; a frame already in flight completes.
- `halt` in 1: CPU halt indication.
- `pc` in `DATA_W`: current PC.
- `regs` in `8*DATA_W`: R0..R7 flattened; R0 at bits `[DATA_W-1:0]`, R7 in the MSBs.
- `tx_data` out 8: current frame byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts the byte; a handshake occurs on a rising edge with `tx_valid && tx_ready`.
- `busy` out 1: a frame is in flight (state ≠ IDLE).
- `overrun` out 8: saturating count of lost snapshots.

## Operation
- **Frame layout**, `F = 9*B + 2` bytes (38 for `DATA_W=32`), in this order:
  - Sync byte: `0xA5` normally, `0x5A` if the frame was caused by a halt trigger.
  - PC, big-endian (MSB byte first).
  - R0 through R7 in order, each big-endian.
  - Checksum: XOR of all `9*B` payload bytes. Sync is excluded.
- **Trigger** is sampled each edge when `en=1`. It fires if any of these holds:
  - `first` is set (set by reset, cleared by the first trigger);
  - `pc != last_pc`;
  - `halt` rises (`halt=1`, `halt_q=0`).
- `last_pc` and `halt_q` update on every trigger, whether the trigger is captured or coalesced.
- **States:** IDLE, SYNC, PAYLOAD, CSUM.
  - IDLE: on an edge with a trigger or `pending` set, latch `pc`, `regs` and the halt flag into a shadow snapshot, clear `pending`, reset the checksum, and go to SYNC.
  - SYNC → PAYLOAD on handshake.
  - PAYLOAD: a byte index 0..`9*B-1` advances on each handshake; the checksum XORs in each accepted byte; after the last payload byte, go to CSUM.
  - CSUM → IDLE on handshake.
- **Trigger while busy** (includes the edge of the final CSUM handshake):
  - If `pending=0`: set `pending`. The snapshot is taken later, from the live inputs at the IDLE capture edge (coalescing).
  - If `pending=1`: increment `overrun`, saturating at 255.
  - A halt trigger while busy sets a `pending_halt` flag, which makes the next frame use sync `0x5A`.
- Snapshot values are frozen for the whole frame; input changes mid-frame never corrupt the frame.
- `tx_data` and `tx_valid` are registered and must stay stable while `tx_valid && !tx_ready`.

## Timing
- **Reset values:** `tx_valid=0`, `tx_data=0x00`, `busy=0`, `overrun=0`, state IDLE, `pending=0`, `first=1`, `last_pc=0`, `halt_q=0`.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously); the partial frame is abandoned and never resumed.
- **Latency:** trigger seen at edge t, then `tx_valid=1` with the sync byte from just after edge t; `busy=1` in the same cycle.
- With `tx_ready` held high, a frame occupies exactly `F` consecutive cycles, followed by at least 1 IDLE cycle with `tx_valid=0`. Minimum frame-to-frame period is `F+1` cycles.
- `tx_ready` deasserted: the byte is held; stall length is unbounded.
- `en` falling mid-frame: the frame finishes; `pending` is kept and still served in IDLE even if `en=0`.

## Test plan
- **First frame:** release reset with `en=1`, `pc=0`, `regs` R_i = `0x11111111*i`, `tx_ready=1`. Expect:
  - bytes `A5 00 00 00 00`, then `00 00 00 00`, then `11 11 11 11` … `77 77 77 77`;
  - checksum `0x00`;
  - 38 consecutive valid cycles, then `busy=0`.
- **Snapshot freeze / coalescing:** `pc` 0→4 (frame starts), then 8, 12, 16 during the frame.
  - First frame carries PC `0x00000004`.
  - Second frame carries PC = value at the IDLE capture edge (16).
  - `overrun=2`.
- **Backpressure:** toggle `tx_ready` pseudo-randomly.
  - `tx_data` is stable whenever `tx_valid && !tx_ready`.
  - The byte sequence is identical to the ready-high run.
  - The checksum is correct (compare against a reference XOR).
- **Halt:** `halt` 0→1 with `pc` unchanged. Expect a frame with sync `0x5A`. `halt` held high produces no further frames.
- **Reset mid-frame:** assert `rst=0` at byte 10. Expect:
  - `tx_valid=0` before the next edge;
  - after release, a fresh frame starting with `A5`;
  - `overrun=0`.
- **Overrun saturation:** force 300 PC changes while `tx_ready=0`. Expect `overrun` = 255, no wrap.
